// File: rtl/alu_pkg.sv
// Shared ALU/sequencer definitions: opcodes, flags-byte layout, sequencer states.
// No latency or backpressure of its own (types and constants only).
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'b1000;
    localparam logic [3:0] OP_SUB = 4'b1010;
    localparam logic [3:0] OP_AND = 4'b1100;
    localparam logic [3:0] OP_OR  = 4'b1101;
    localparam logic [3:0] OP_XOR = 4'b1110;
    localparam logic [3:0] OP_SRA = 4'b0011;
    localparam logic [3:0] OP_SRL = 4'b0010;

    localparam int FLG_ZERO  = 0;
    localparam int FLG_CARRY = 1;
    localparam int FLG_OVF   = 2;
    localparam int FLG_NEG   = 3;
    localparam int FLG_EXC   = 4;

    typedef enum logic [2:0] {
        ST_WAIT_A   = 3'd0,
        ST_WAIT_B   = 3'd1,
        ST_WAIT_OP  = 3'd2,
        ST_EXEC     = 3'd3,
        ST_SEND_RES = 3'd4,
        ST_WAIT_RES = 3'd5,
        ST_SEND_FLG = 3'd6,
        ST_WAIT_FLG = 3'd7
    } seq_state_t;

    function automatic logic [7:0] pack_flags(input logic zero, input logic carry,
                                              input logic ovf, input logic neg,
                                              input logic exc);
        logic [7:0] f;
        f            = 8'h00;
        f[FLG_ZERO]  = zero;
        f[FLG_CARRY] = carry;
        f[FLG_OVF]   = ovf;
        f[FLG_NEG]   = neg;
        f[FLG_EXC]   = exc;
        return f;
    endfunction

    // Only the three collecting states may take a new byte; anywhere else it is an overrun.
    function automatic logic accepts_rx(input seq_state_t s);
        return (s == ST_WAIT_A) || (s == ST_WAIT_B) || (s == ST_WAIT_OP);
    endfunction

endpackage

// File: rtl/alu_uart_sequencer_timeout.sv
// Inter-byte idle counter: clears on clr_i, counts while en_i, term_o when the last count is reached.
// term_o is combinational in the last counting cycle; a same-cycle clr_i suppresses it.
module seq_timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic term_o
);

    localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign term_o = en_i && !clr_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || term_o) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/alu_uart_sequencer.sv
// Collects A, B, opcode bytes from the UART, runs the ALU for one cycle, returns result then flags.
// First tx start two cycles after the opcode byte; bytes arriving while busy are dropped (o_overrun).
module alu_uart_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic [DATA_WIDTH-1:0] i_rx_data,
    input  logic                  i_rx_done,
    input  logic                  i_tx_done,
    output logic [DATA_WIDTH-1:0] o_tx_data,
    output logic                  o_tx_start,
    output logic [DATA_WIDTH-1:0] o_operandA,
    output logic [DATA_WIDTH-1:0] o_operandB,
    output logic [3:0]            o_opcode,
    input  logic [DATA_WIDTH-1:0] i_result,
    input  logic                  i_zero,
    input  logic                  i_carry,
    input  logic                  i_overflow,
    input  logic                  i_negative,
    input  logic                  i_exception,
    output logic                  o_busy,
    output logic                  o_timeout,
    output logic                  o_overrun
);

    seq_state_t            state_q, state_d;
    logic [DATA_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0] b_q, b_d;
    logic [3:0]            op_q, op_d;
    logic [DATA_WIDTH-1:0] res_q, res_d;
    logic [DATA_WIDTH-1:0] flg_q, flg_d;
    logic                  timeout_q, timeout_d;
    logic                  overrun_q, overrun_d;

    logic cnt_en;
    logic cnt_clr;
    logic cnt_term;

    assign cnt_en  = (state_q == ST_WAIT_B) || (state_q == ST_WAIT_OP);
    assign cnt_clr = i_rx_done || !cnt_en;

    seq_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i (i_clock),
        .rst_ni(i_reset),
        .clr_i (cnt_clr),
        .en_i  (cnt_en),
        .term_o(cnt_term)
    );

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        res_d     = res_q;
        flg_d     = flg_q;
        timeout_d = 1'b0;
        overrun_d = i_rx_done && !accepts_rx(state_q);

        case (state_q)
            ST_WAIT_A: begin
                if (i_rx_done) begin
                    a_d     = i_rx_data;
                    state_d = ST_WAIT_B;
                end
            end
            ST_WAIT_B: begin
                if (i_rx_done) begin
                    b_d     = i_rx_data;
                    state_d = ST_WAIT_OP;
                end else if (cnt_term) begin
                    timeout_d = 1'b1;
                    a_d       = '0;
                    b_d       = '0;
                    op_d      = '0;
                    state_d   = ST_WAIT_A;
                end
            end
            ST_WAIT_OP: begin
                if (i_rx_done) begin
                    op_d    = i_rx_data[3:0];
                    state_d = ST_EXEC;
                end else if (cnt_term) begin
                    timeout_d = 1'b1;
                    a_d       = '0;
                    b_d       = '0;
                    op_d      = '0;
                    state_d   = ST_WAIT_A;
                end
            end
            ST_EXEC: begin
                // An ALU exception reports a zero result regardless of what the ALU drives.
                res_d   = i_exception ? '0 : i_result;
                flg_d   = DATA_WIDTH'(pack_flags(i_zero, i_carry, i_overflow,
                                                 i_negative, i_exception));
                state_d = ST_SEND_RES;
            end
            ST_SEND_RES: state_d = ST_WAIT_RES;
            ST_WAIT_RES: begin
                if (i_tx_done) begin
                    state_d = ST_SEND_FLG;
                end
            end
            ST_SEND_FLG: state_d = ST_WAIT_FLG;
            ST_WAIT_FLG: begin
                if (i_tx_done) begin
                    state_d = ST_WAIT_A;
                end
            end
            default: state_d = ST_WAIT_A;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q   <= ST_WAIT_A;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            res_q     <= '0;
            flg_q     <= '0;
            timeout_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            res_q     <= res_d;
            flg_q     <= flg_d;
            timeout_q <= timeout_d;
            overrun_q <= overrun_d;
        end
    end

    // Byte selection follows the state so the data stays put until the transmitter is done.
    assign o_tx_data  = ((state_q == ST_SEND_RES) || (state_q == ST_WAIT_RES)) ? res_q :
                        ((state_q == ST_SEND_FLG) || (state_q == ST_WAIT_FLG)) ? flg_q : '0;
    assign o_tx_start = (state_q == ST_SEND_RES) || (state_q == ST_SEND_FLG);
    assign o_operandA = a_q;
    assign o_operandB = b_q;
    assign o_opcode   = op_q;
    assign o_busy     = (state_q != ST_WAIT_A);
    assign o_timeout  = timeout_q;
    assign o_overrun  = overrun_q;

endmodule

// File: doc/alu_uart_sequencer.md
Name: alu_uart_sequencer

Overview:
Sequencer between the UART byte stream and the 8-bit ALU. It collects three received bytes (operand A, operand B, opcode) and drives them to the ALU. It then captures the ALU result and flags and returns two bytes to the UART transmitter: the result byte followed by the flags byte. It sits between the UART rx/tx blocks and the ALU in the top level.

Parameters:
DATA_WIDTH, 8, operand/result width; also the UART byte width
TIMEOUT_CYCLES, 100000, maximum idle clocks allowed between bytes of one command before the command is discarded

Ports:
i_clock  in  1  system clock
i_reset  in  1  asynchronous, active-low reset
i_rx_data  in  DATA_WIDTH  received byte, valid when i_rx_done=1
i_rx_done  in  1  one-cycle pulse: new byte available
i_tx_done  in  1  one-cycle pulse: transmitter finished the current byte
o_tx_data  out  DATA_WIDTH  byte to transmit, held stable from o_tx_start until i_tx_done
o_tx_start  out  1  one-cycle pulse: start transmitting o_tx_data
o_operandA  out  DATA_WIDTH  registered operand A to the ALU
o_operandB  out  DATA_WIDTH  registered operand B to the ALU
o_opcode  out  4  registered opcode to the ALU (low nibble of the opcode byte)
i_result  in  DATA_WIDTH  ALU result (combinational)
i_zero, i_carry, i_overflow, i_negative, i_exception  in  1 each  ALU flags
o_busy  out  1  high in any state other than WAIT_A
o_timeout  out  1  one-cycle pulse: partial command discarded
o_overrun  out  1  one-cycle pulse: byte received while executing or sending, byte dropped

Behaviour:
- Reset (i_reset=0, asynchronous): state=WAIT_A; all outputs and internal registers are 0.
- States: WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND_RES, WAIT_RES, SEND_FLG, WAIT_FLG.
- WAIT_A: on i_rx_done, latch o_operandA=i_rx_data and go to WAIT_B.
- WAIT_B: on i_rx_done, latch o_operandB and go to WAIT_OP.
- WAIT_OP: on i_rx_done, latch o_opcode=i_rx_data[3:0] and go to EXEC. The upper nibble is ignored.
- EXEC (exactly one cycle): capture the ALU outputs.
  - res_q = i_exception ? 0 : i_result.
  - flg_q = {3'b000, i_exception, i_negative, i_overflow, i_carry, i_zero}.
  - Go to SEND_RES.
- SEND_RES (one cycle): o_tx_data=res_q, o_tx_start=1, go to WAIT_RES.
- WAIT_RES: hold o_tx_data; on i_tx_done go to SEND_FLG.
- SEND_FLG (one cycle): o_tx_data=flg_q, o_tx_start=1, go to WAIT_FLG.
- WAIT_FLG: on i_tx_done go to WAIT_A.
- Latency: the opcode byte's i_rx_done is in cycle N; EXEC is N+1; the first o_tx_start is N+2.
- Timeout counter:
  - Counts only in WAIT_B and WAIT_OP; cleared on every i_rx_done and in all other states.
  - When the count reaches TIMEOUT_CYCLES-1 with no i_rx_done: pulse o_timeout, return to WAIT_A, clear A/B/opcode.
  - If i_rx_done arrives in the same cycle as the timeout: the byte wins and no timeout occurs.
- i_rx_done in EXEC, SEND_*, or WAIT_*: byte dropped, o_overrun pulses for one cycle, state unaffected.
- i_tx_done outside WAIT_RES/WAIT_FLG: ignored.
- o_operandA, o_operandB and o_opcode hold their values after a command completes, until overwritten or timed out.
- Reset asserted mid-operation: immediate return to WAIT_A; no further tx pulses.

Decomposition:
- Shared package alu_pkg holds:
  - Opcode constants: ADD=4'b1000, SUB=4'b1010, AND=4'b1100, OR=4'b1101, XOR=4'b1110, SRA=4'b0011, SRL=4'b0010.
  - Flags-byte bit positions: ZERO=0, CARRY=1, OVF=2, NEG=3, EXC=4.
  - The state encoding.
- One natural sub-module: seq_timeout_counter (load/clear/enable, terminal pulse).

Test Plan:
- Rx 0x05, 0x03, 0x08 (ADD) -> ALU sees A=5, B=3, op=8; tx 0x08 then 0x00; first o_tx_start exactly 2 cycles after the third i_rx_done.
- Rx 0x7F, 0x01, 0x08 -> tx 0x80 then 0x0C (overflow + negative).
- Rx 0x03, 0x05, 0x0A (SUB) -> tx 0xFE then 0x0A (carry + negative); rx 0x00, 0x00, 0x0C (AND) -> tx 0x00 then 0x01 (zero).
- Rx 0x12, 0x34, 0x0F (undefined opcode) -> tx 0x00 then 0x10; the next command proceeds normally.
- Rx 0x11, then idle for TIMEOUT_CYCLES -> o_timeout pulses once; then rx 0x02, 0x02, 0x08 -> tx 0x04, 0x00.
- Inject i_rx_done during WAIT_RES -> o_overrun pulses and output bytes are unchanged; assert reset in WAIT_FLG -> all outputs 0, state WAIT_A, no o_tx_start afterward.
